pipe_seq_ctrl: RTL and testbench
================================

PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, address width of read/write buffers.
REQ-002 Parameter RD_LAT, default 1, read-port latency in cycles (1..4).
REQ-003 Parameter PE_LAT, default 1, processing-element latency in cycles (1..8).
REQ-004 clk  in  1  clock, all logic rising-edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 clr  in  1  synchronous abort to IDLE.
REQ-007 start  in  1  request a burst; sampled only while ready=1.
REQ-008 len  in  ADDR_W  burst length; 0 encodes 2^ADDR_W.
REQ-009 rd_base  in  ADDR_W  first read address.
REQ-010 wr_base  in  ADDR_W  first write address.
REQ-011 hold  in  1  stall; freezes all sequencing while 1.
REQ-012 ready  out  1  idle, start accepted.
REQ-013 busy  out  1  burst in progress (not IDLE).
REQ-014 done_tick  out  1  one-cycle pulse at burst completion.
REQ-015 en_rd / addr_rd  out  1 / ADDR_W  read enable and address.
REQ-016 en_pe  out  1  PE enable.
REQ-017 en_wr / addr_wr  out  1 / ADDR_W  write enable and address.

Function
REQ-018 States: IDLE, RUN (reads issuing), DRAIN (reads done, PE/writes outstanding), DONE (one cycle).
REQ-019 IDLE->RUN when start=1 and ready=1 in cycle 0; len, rd_base, wr_base latched that cycle; start with ready=0 ignored.
REQ-020 Unstalled timing, L = effective length: en_rd cycles 1..L, en_pe cycles 1+RD_LAT..L+RD_LAT, en_wr cycles 1+RD_LAT+PE_LAT..L+RD_LAT+PE_LAT.
REQ-021 k-th beat (k=0..L-1): addr_rd = rd_base+k, addr_wr = wr_base+k, modulo 2^ADDR_W (wrap-around, no error).
REQ-022 RUN->DRAIN after the cycle with the L-th en_rd; DRAIN->DONE after the cycle with the L-th en_wr; DONE->IDLE unconditionally.
REQ-023 done_tick=1 only in DONE, i.e. cycle L+RD_LAT+PE_LAT+1 unstalled; ready=1 from the following cycle.
REQ-024 ready=1 iff IDLE; busy = not ready; back-to-back start accepted in the first cycle ready=1.
REQ-025 hold=1: en_rd, en_pe, en_wr forced 0; state, counters and delay pipeline frozen; addresses held; released beats resume exactly where stopped.
REQ-026 hold during IDLE has no effect on ready; hold in DONE delays done_tick until hold=0.
REQ-027 clr=1: next cycle IDLE, all enables 0, addresses 0, no done_tick; clr beats start and hold in the same cycle.
REQ-028 Outputs are registered or decoded from registered state only; no combinational path from start/len to any enable.
REQ-029 With ADDR_W=4, RD_LAT=1, PE_LAT=1, len=4, base 0: timing identical to the legacy fixed 4-beat controller (en_rd 1-4, en_pe 2-5, en_wr 3-6, done 7).

Reset
REQ-030 rst_n=0: state IDLE, ready=1, busy=0, done_tick=0, all enables 0, addr_rd=addr_wr=0, delay pipeline cleared.
REQ-031 Reset mid-burst behaves as clr; no partial beats after release.

Structure
REQ-032 Shared package ctrl_pkg holds state encoding and latency limit constants.
REQ-033 Sub-module ctrl_delay (parameters WIDTH, DEPTH, with hold-enable and sync clear) delays the read-beat valid to form en_pe and en_wr.
REQ-034 Write address generated by its own counter advanced by delayed valid, not by delaying addr_rd.

Verification
REQ-035 Defaults, len=4, bases 0, start at cycle 0 -> en_rd 1-4 addr 0-3, en_pe 2-5, en_wr 3-6 addr 0-3, done_tick cycle 7, ready cycle 8.
REQ-036 len=0 (16 beats), rd_base=14, wr_base=3 -> addr_rd 14,15,0..13; addr_wr 3..15,0,1,2; done_tick cycle 19.
REQ-037 RD_LAT=2, PE_LAT=3, len=3, hold=1 cycles 2-3 -> 3 reads, 3 PE, 3 writes, no beat lost/duplicated, done_tick cycle 11.
REQ-038 clr at cycle 3 of len=8 burst -> cycle 4 IDLE, enables 0, no done_tick; new start then runs normally.
REQ-039 start asserted continuously -> second burst accepted in first ready cycle; start during busy ignored.
REQ-040 rst_n=0 mid-DRAIN -> all outputs at reset values next cycle, ready=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared state encoding and latency limits for the pipelined burst sequencer.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int PE_LAT_MIN = 1;
  localparam int PE_LAT_MAX = 8;

endpackage

// File: rtl/ctrl_delay.sv
// Stallable shift-register delay line with synchronous clear; output is the last stage.
module ctrl_delay
  import ctrl_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!rst_n || clr) q_reg <= '0;
          else if (en)       q_reg <= din;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (!rst_n || clr) q_reg <= '0;
          else if (en)       q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Burst sequencer: issues L read beats, then PE and write beats delayed by fixed
// latencies; hold freezes everything, clr aborts to IDLE.
module pipe_seq_ctrl
  import ctrl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1,
  parameter int PE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic              hold,
  output logic              ready,
  output logic              busy,
  output logic              done_tick,
  output logic              en_rd,
  output logic [ADDR_W-1:0] addr_rd,
  output logic              en_pe,
  output logic              en_wr,
  output logic [ADDR_W-1:0] addr_wr
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("pipe_seq_ctrl: RD_LAT out of range");
  end
  if (PE_LAT < PE_LAT_MIN || PE_LAT > PE_LAT_MAX) begin : g_bad_pe_lat
    $error("pipe_seq_ctrl: PE_LAT out of range");
  end

  localparam logic [ADDR_W:0] LEFT_LAST = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [ADDR_W:0]   rd_left_reg;
  logic [ADDR_W:0]   wr_left_reg;
  logic [ADDR_W:0]   eff_len;
  logic              pe_vld;
  logic              wr_vld;

  // len of zero means a full 2^ADDR_W burst
  assign eff_len   = {(len == '0), len};

  assign ready     = (state_reg == ST_IDLE);
  assign busy      = ~ready;
  assign done_tick = (state_reg == ST_DONE) & ~hold;
  assign en_rd     = (state_reg == ST_RUN) & ~hold;
  assign en_pe     = pe_vld & ~hold;
  assign en_wr     = wr_vld & ~hold;
  assign addr_rd   = rd_addr_reg;
  assign addr_wr   = wr_addr_reg;

  ctrl_delay #(.WIDTH(1), .DEPTH(RD_LAT)) u_pe_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (~hold),
    .din   (en_rd),
    .dout  (pe_vld)
  );

  ctrl_delay #(.WIDTH(1), .DEPTH(PE_LAT)) u_wr_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (~hold),
    .din   (en_pe),
    .dout  (wr_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_reg   <= ST_IDLE;
      rd_addr_reg <= '0;
      wr_addr_reg <= '0;
      rd_left_reg <= '0;
      wr_left_reg <= '0;
    end else begin
      // write beats may overlap the tail of the read phase
      if (en_wr) begin
        wr_addr_reg <= wr_addr_reg + 1'b1;
        wr_left_reg <= wr_left_reg - 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg   <= ST_RUN;
            rd_addr_reg <= rd_base;
            wr_addr_reg <= wr_base;
            rd_left_reg <= eff_len;
            wr_left_reg <= eff_len;
          end
        end
        ST_RUN: begin
          if (en_rd) begin
            rd_addr_reg <= rd_addr_reg + 1'b1;
            rd_left_reg <= rd_left_reg - 1'b1;
            if (rd_left_reg == LEFT_LAST) state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (en_wr && wr_left_reg == LEFT_LAST) state_reg <= ST_DONE;
        end
        ST_DONE: begin
          if (!hold) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Runs two sequencers (latencies 1/1 and 2/3) on shared stimulus against a
// time-based burst model: each burst is a timeline advanced only on unheld cycles.
module tb_pipe_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, clr, start, hold;
  logic [3:0] len, rd_base, wr_base;

  logic       ready_1, busy_1, done_1, en_rd_1, en_pe_1, en_wr_1;
  logic [3:0] addr_rd_1, addr_wr_1;
  logic       ready_2, busy_2, done_2, en_rd_2, en_pe_2, en_wr_2;
  logic [3:0] addr_rd_2, addr_wr_2;

  pipe_seq_ctrl #(.ADDR_W(4), .RD_LAT(1), .PE_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .len(len),
    .rd_base(rd_base), .wr_base(wr_base), .hold(hold),
    .ready(ready_1), .busy(busy_1), .done_tick(done_1),
    .en_rd(en_rd_1), .addr_rd(addr_rd_1), .en_pe(en_pe_1),
    .en_wr(en_wr_1), .addr_wr(addr_wr_1)
  );

  pipe_seq_ctrl #(.ADDR_W(4), .RD_LAT(2), .PE_LAT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .len(len),
    .rd_base(rd_base), .wr_base(wr_base), .hold(hold),
    .ready(ready_2), .busy(busy_2), .done_tick(done_2),
    .en_rd(en_rd_2), .addr_rd(addr_rd_2), .en_pe(en_pe_2),
    .en_wr(en_wr_2), .addr_wr(addr_wr_2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // burst model per DUT: active flag, position u on the unstalled timeline, burst params
  int lat_rd [2] = '{1, 2};
  int lat_pe [2] = '{1, 3};
  int m_act  [2] = '{0, 0};
  int m_u    [2];
  int m_len  [2];
  int m_rb   [2];
  int m_wb   [2];

  // vector: [13]ready [12]busy [11]done [10]en_rd [9:6]addr_rd [5]en_pe [4]en_wr [3:0]addr_wr
  logic [13:0] obs1, obs2, exp1, exp2;
  logic [15:0] raw_addr;

  function automatic logic [13:0] model_out(int d, logic h);
    logic [13:0] v;
    int rl, pl, u, l;
    rl = lat_rd[d];
    pl = lat_pe[d];
    u  = m_u[d];
    l  = m_len[d];
    v  = '0;
    if (m_act[d] == 0) begin
      v[13] = 1'b1;
    end else begin
      v[12] = 1'b1;
      if (!h) begin
        if (u >= 1 && u <= l) begin
          v[10]  = 1'b1;
          v[9:6] = 4'((m_rb[d] + u - 1) & 15);
        end
        if (u >= 1 + rl && u <= l + rl) v[5] = 1'b1;
        if (u >= 1 + rl + pl && u <= l + rl + pl) begin
          v[4]   = 1'b1;
          v[3:0] = 4'((m_wb[d] + u - 1 - rl - pl) & 15);
        end
        if (u == l + rl + pl + 1) v[11] = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic model_step(int d, logic s, logic h, logic c, logic r);
    if (!r || c) begin
      m_act[d] = 0;
    end else if (m_act[d] == 0) begin
      if (s) begin
        m_act[d] = 1;
        m_u[d]   = 1;
        m_len[d] = (len == 4'd0) ? 16 : int'(len);
        m_rb[d]  = int'(rd_base);
        m_wb[d]  = int'(wr_base);
        if (d == 0)
          $display("burst cycle=%0d len=%0d rd_base=%0d wr_base=%0d", cyc, m_len[d], m_rb[d], m_wb[d]);
      end
    end else if (!h) begin
      if (m_u[d] == m_len[d] + lat_rd[d] + lat_pe[d] + 1) m_act[d] = 0;
      else m_u[d] = m_u[d] + 1;
    end
  endtask

  // drive one cycle, capture observed/expected at negedge, advance model past the edge
  task automatic drive(input logic s, input logic h, input logic c, input logic r);
    start = s; hold = h; clr = c; rst_n = r;
    @(negedge clk);
    exp1 = model_out(0, h);
    exp2 = model_out(1, h);
    obs1 = {ready_1, busy_1, done_1, en_rd_1, (en_rd_1 ? addr_rd_1 : 4'h0),
            en_pe_1, en_wr_1, (en_wr_1 ? addr_wr_1 : 4'h0)};
    obs2 = {ready_2, busy_2, done_2, en_rd_2, (en_rd_2 ? addr_rd_2 : 4'h0),
            en_pe_2, en_wr_2, (en_wr_2 ? addr_wr_2 : 4'h0)};
    raw_addr = {addr_rd_1, addr_wr_1, addr_rd_2, addr_wr_2};
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) model_step(d, s, h, c, r);
    cyc++;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, (i >= 2));
      checks++;
      if ({obs1, obs2} !== {exp1, exp2}) begin
        errors++;
        $display("FAIL reset_state i=%0d got=%h want=%h", i, {obs1, obs2}, {exp1, exp2});
      end
      checks++;
      if (raw_addr !== 16'h0) begin
        errors++;
        $display("FAIL reset_addr i=%0d got=%h want=0", i, raw_addr);
      end
    end
  endtask

  task automatic test_basic();
    int d1, d2;
    d1 = -1; d2 = -1;
    len = 4'd4; rd_base = 4'd0; wr_base = 4'd0;
    for (int i = 0; i < 30; i++) begin
      drive((i == 0), 1'b0, 1'b0, 1'b1);
      checks++;
      if ({obs1, obs2} !== {exp1, exp2}) begin
        errors++;
        $display("FAIL basic cycle=%0d got=%h want=%h", i, {obs1, obs2}, {exp1, exp2});
      end
      if (obs1[11] && d1 < 0) d1 = i;
      if (obs2[11] && d2 < 0) d2 = i;
    end
    checks++;
    if (d1 !== 7) begin errors++; $display("FAIL basic_done1 got=%0d want=7", d1); end
    checks++;
    if (d2 !== 10) begin errors++; $display("FAIL basic_done2 got=%0d want=10", d2); end
  endtask

  task automatic test_wrap();
    int d1;
    d1 = -1;
    len = 4'd0; rd_base = 4'd14; wr_base = 4'd3;
    for (int i = 0; i < 30; i++) begin
      drive((i == 0), 1'b0, 1'b0, 1'b1);
      checks++;
      if ({obs1, obs2} !== {exp1, exp2}) begin
        errors++;
        $display("FAIL wrap cycle=%0d got=%h want=%h", i, {obs1, obs2}, {exp1, exp2});
      end
      if (obs1[11] && d1 < 0) d1 = i;
    end
    checks++;
    if (d1 !== 19) begin errors++; $display("FAIL wrap_done1 got=%0d want=19", d1); end
  endtask

  task automatic test_hold();
    int d1, d2;
    d1 = -1; d2 = -1;
    len = 4'd3; rd_base = 4'd5; wr_base = 4'd9;
    for (int i = 0; i < 25; i++) begin
      drive((i == 0), (i == 2 || i == 3), 1'b0, 1'b1);
      checks++;
      if ({obs1, obs2} !== {exp1, exp2}) begin
        errors++;
        $display("FAIL hold cycle=%0d got=%h want=%h", i, {obs1, obs2}, {exp1, exp2});
      end
      if (obs1[11] && d1 < 0) d1 = i;
      if (obs2[11] && d2 < 0) d2 = i;
    end
    checks++;
    if (d1 !== 8) begin errors++; $display("FAIL hold_done1 got=%0d want=8", d1); end
    checks++;
    if (d2 !== 11) begin errors++; $display("FAIL hold_done2 got=%0d want=11", d2); end
  endtask

  task automatic test_clr();
    len = 4'd8; rd_base = 4'd2; wr_base = 4'd7;
    for (int i = 0; i < 30; i++) begin
      drive((i == 0 || i == 6), 1'b0, (i == 3), 1'b1);
      checks++;
      if ({obs1, obs2} !== {exp1, exp2}) begin
        errors++;
        $display("FAIL clr cycle=%0d got=%h want=%h", i, {obs1, obs2}, {exp1, exp2});
      end
      if (i == 4) begin
        checks++;
        if (raw_addr !== 16'h0 || !obs1[13] || !obs2[13]) begin
          errors++;
          $display("FAIL clr_idle addr=%h ready=%b%b want addr=0 ready=11", raw_addr, obs1[13], obs2[13]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    n1 = 0; n2 = 0;
    len = 4'd2; rd_base = 4'd12; wr_base = 4'd1;
    for (int i = 0; i < 45; i++) begin
      drive((i < 20), 1'b0, 1'b0, 1'b1);
      checks++;
      if ({obs1, obs2} !== {exp1, exp2}) begin
        errors++;
        $display("FAIL b2b cycle=%0d got=%h want=%h", i, {obs1, obs2}, {exp1, exp2});
      end
      if (i < 20 && obs1[11]) n1++;
      if (i < 20 && obs2[11]) n2++;
    end
    checks++;
    if (n1 !== 3 || n2 !== 2) begin
      errors++;
      $display("FAIL b2b_count got=%0d,%0d want=3,2", n1, n2);
    end
  endtask

  task automatic test_reset_mid();
    len = 4'd4; rd_base = 4'd3; wr_base = 4'd11;
    for (int i = 0; i < 20; i++) begin
      drive((i == 0), 1'b0, 1'b0, (i != 5));
      checks++;
      if ({obs1, obs2} !== {exp1, exp2}) begin
        errors++;
        $display("FAIL rst_mid cycle=%0d got=%h want=%h", i, {obs1, obs2}, {exp1, exp2});
      end
      if (i == 6) begin
        checks++;
        if (raw_addr !== 16'h0 || !obs1[13] || !obs2[13]) begin
          errors++;
          $display("FAIL rst_mid_idle addr=%h ready=%b%b want addr=0 ready=11", raw_addr, obs1[13], obs2[13]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic s, h, c;
    for (int i = 0; i < 430; i++) begin
      len     = 4'($urandom_range(0, 15));
      rd_base = 4'($urandom_range(0, 15));
      wr_base = 4'($urandom_range(0, 15));
      h = (i < 400) && ($urandom_range(0, 4) == 0);
      s = (i < 400) && !h && ($urandom_range(0, 3) == 0);
      c = (i < 400) && ($urandom_range(0, 60) == 0);
      drive(s, h, c, 1'b1);
      checks++;
      if ({obs1, obs2} !== {exp1, exp2}) begin
        errors++;
        $display("FAIL random cycle=%0d got=%h want=%h", i, {obs1, obs2}, {exp1, exp2});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; start = 1'b0; hold = 1'b0;
    len = 4'd0; rd_base = 4'd0; wr_base = 4'd0;
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_clr();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
